// File: rtl/serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx
// Receive-side serial-to-parallel converter for one PHY lane. It hunts the
// incoming bit stream for the COM symbol to find byte alignment. Once enough
// consecutive aligned COMs have been seen, it declares the lane active. From
// then on it presents every received byte, flagging the non-COM ones as valid.
//
// Ports
//   clk_8f    in   1  bit clock (8x byte rate); all logic on the rising edge
//   reset     in   1  synchronous, active-high reset
//   data_in   in   1  serial bit, MSB of each byte first
//   data_out  out  8  last byte received while active
//   valid_out out  1  data_out holds a non-COM byte received while active
//   active    out  1  lane aligned and locked (only reset clears it)
// ---------------------------------------------------------------------------
module serial_paralelo_rx #(
   parameter logic [7:0]  COM     = 8'hBC,
   parameter int unsigned NUM_COM = 4
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH,
      LOCK,
      ACTIVE
   } state_t;

   localparam logic [4:0] NUM_COM_W = 5'(NUM_COM);

   state_t     state;
   state_t     state_next;
   logic [6:0] sr;
   logic [7:0] nxt;
   logic [2:0] bit_cnt;
   logic [2:0] bit_cnt_next;
   logic [3:0] com_cnt;
   logic [3:0] com_cnt_next;
   logic [7:0] data_next;
   logic       valid_next;
   logic       active_next;
   logic       boundary;
   logic       is_com;

   // The byte that would be complete after this edge. Only seven history bits
   // need to be stored, because the eighth bit is the current data_in.
   assign nxt      = {sr, data_in};
   assign is_com   = (nxt == COM);
   assign boundary = (bit_cnt == 3'd7);

   // The shifter keeps running through reset. As a result, a COM that starts
   // arriving while reset is still high can be recognised on the first
   // edge after reset is released.
   always_ff @(posedge clk_8f) begin
      sr <= nxt[6:0];
   end

   // State and output registers. Reset overrides everything, including
   // a partially received byte or a partially completed lock attempt.
   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state     <= SEARCH;
         bit_cnt   <= 3'd0;
         com_cnt   <= 4'd0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         com_cnt   <= com_cnt_next;
         data_out  <= data_next;
         valid_out <= valid_next;
         active    <= active_next;
      end
   end

   // Next-state logic. SEARCH tests every bit position for a COM. LOCK checks
   // that a COM lands on each following byte boundary. In ACTIVE, a byte is
   // delivered at each boundary.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      com_cnt_next = com_cnt;
      data_next    = data_out;
      valid_next   = valid_out;
      active_next  = active;

      unique case (state)
         SEARCH: begin
            if (is_com) begin
               bit_cnt_next = 3'd0;
               com_cnt_next = 4'd1;
               state_next   = LOCK;
            end
         end

         LOCK: begin
            bit_cnt_next = bit_cnt + 3'd1;
            if (boundary) begin
               if (is_com) begin
                  com_cnt_next = com_cnt + 4'd1;
                  if (({1'b0, com_cnt} + 5'd1) == NUM_COM_W) begin
                     state_next  = ACTIVE;
                     active_next = 1'b1;
                  end
               end else begin
                  // The alignment guess was wrong. Hunting restarts on the
                  // next edge, so this failed byte is not examined again.
                  com_cnt_next = 4'd0;
                  state_next   = SEARCH;
               end
            end
         end

         ACTIVE: begin
            bit_cnt_next = bit_cnt + 3'd1;
            if (boundary) begin
               data_next  = nxt;
               valid_next = !is_com;
            end
         end

         default: begin
            state_next = SEARCH;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Self-checking bench for serial_paralelo_rx. Every bit driven into the lane
// is recorded. After each edge, a reference model recomputes the expected
// outputs from that bit history alone. The model finds the first COM
// position that is followed by NUM_COM-1 COMs on byte boundaries, and from
// there reads off bytes every eight bits. Directed checks pin the lock and
// byte edges that the design must hit.
// ---------------------------------------------------------------------------
module tb_serial_paralelo_rx;

   localparam logic [7:0] COM     = 8'hBC;
   localparam int         NUM_COM = 4;

   logic       clk_8f;
   logic       reset;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int total;
   int bad;
   bit hist[$];
   int rst_idx;

   serial_paralelo_rx #(
      .COM     (COM),
      .NUM_COM (NUM_COM)
   ) dut (
      .clk_8f    (clk_8f),
      .reset     (reset),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active    (active)
   );

   // 10 ns bit clock
   initial begin
      clk_8f = 1'b0;
      forever #5 clk_8f = ~clk_8f;
   end

   // Returns the eight history bits that end at index i, with the oldest
   // bit in the MSB position.
   function automatic logic [7:0] win(input int i);
      logic [7:0] w;
      w = 8'h00;
      for (int j = 0; j < 8; j++) begin
         w = {w[6:0], hist[i - 7 + j]};
      end
      return w;
   endfunction

   // Computes the expected outputs after the edge at history index 'last',
   // using only the bits received since the most recent reset edge.
   function automatic void model(input int last, output logic exp_act,
                                 output logic [7:0] exp_d, output logic exp_v);
      int p;
      int k;
      int lock_at;
      exp_act = 1'b0;
      exp_d   = 8'h00;
      exp_v   = 1'b0;
      lock_at = -1;
      p       = rst_idx + 1;
      while (p <= last && lock_at < 0) begin
         if (win(p) == COM) begin
            k = 1;
            while (k < NUM_COM && p + 8 * k <= last && win(p + 8 * k) == COM) k++;
            if (k == NUM_COM) begin
               lock_at = p + 8 * (NUM_COM - 1);
            end else if (p + 8 * k <= last) begin
               p = p + 8 * k + 1;
            end else begin
               break;
            end
         end else begin
            p++;
         end
      end
      if (lock_at >= 0) begin
         exp_act = 1'b1;
         for (int e = lock_at + 8; e <= last; e += 8) begin
            exp_d = win(e);
            exp_v = (exp_d != COM);
         end
      end
   endfunction

   function automatic int edgeNo();
      return hist.size() - 1 - rst_idx;
   endfunction

   // Compares all three outputs against the reference model
   task automatic checkOutput();
      logic       ea;
      logic [7:0] ed;
      logic       ev;
      model(hist.size() - 1, ea, ed, ev);
      total++;
      assert (active === ea) else begin
         bad++;
         $error("[TB] FAIL active edge=%0d got=%b exp=%b", edgeNo(), active, ea);
      end
      total++;
      assert (data_out === ed) else begin
         bad++;
         $error("[TB] FAIL data_out edge=%0d got=%h exp=%h", edgeNo(), data_out, ed);
      end
      total++;
      assert (valid_out === ev) else begin
         bad++;
         $error("[TB] FAIL valid_out edge=%0d got=%b exp=%b", edgeNo(), valid_out, ev);
      end
   endtask

   // Drives one bit for one edge, records it, and checks the outputs after
   // that edge
   task automatic applyStimulus(input bit b, input bit r);
      data_in = b;
      reset   = r;
      @(posedge clk_8f);
      #1;
      hist.push_back(b);
      if (r) rst_idx = hist.size() - 1;
      checkOutput();
   endtask

   task automatic sendByte(input logic [7:0] v, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) applyStimulus(v[i], 1'b0);
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1);
   endtask

   task automatic checkDirected(input string tag, input logic [7:0] got,
                                input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s edge=%0d got=%h exp=%h", tag, edgeNo(), got, exp);
      end
   endtask

   initial begin
      logic [7:0] b;
      total   = 0;
      bad     = 0;
      rst_idx = 0;
      data_in = 1'b0;
      reset   = 1'b1;

      // Clean lock: with 4 COMs, active must rise exactly on edge 32
      $display("[TB] clean lock");
      doReset(10);
      checkDirected("reset_active", {7'd0, active}, 8'h00);
      checkDirected("reset_data", data_out, 8'h00);
      for (int i = 0; i < 3; i++) sendByte(COM, 8);
      sendByte(COM, 7);
      checkDirected("edge31_active", {7'd0, active}, 8'h00);
      sendByte(8'h01, 1);
      checkDirected("edge32_active", {7'd0, active}, 8'h01);
      checkDirected("edge32_data", data_out, 8'h00);
      checkDirected("edge32_valid", {7'd0, valid_out}, 8'h00);

      // Data bytes appear on edges 40/48/56/64, followed by COM fill on edge 72
      $display("[TB] data bytes");
      sendByte(8'hFF, 8);
      checkDirected("e40_data", data_out, 8'hFF);
      checkDirected("e40_valid", {7'd0, valid_out}, 8'h01);
      sendByte(8'hEE, 8);
      checkDirected("e48_data", data_out, 8'hEE);
      sendByte(8'hDD, 8);
      checkDirected("e56_data", data_out, 8'hDD);
      sendByte(8'hCC, 8);
      checkDirected("e64_data", data_out, 8'hCC);
      checkDirected("e64_valid", {7'd0, valid_out}, 8'h01);
      sendByte(COM, 8);
      checkDirected("e72_data", data_out, COM);
      checkDirected("e72_valid", {7'd0, valid_out}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         sendByte(b, 8);
         checkDirected("rand_byte", data_out, b);
      end

      // Alignment at bit offset 3, so lock occurs on edge 35
      $display("[TB] offset 3");
      doReset(10);
      for (int i = 0; i < 3; i++) applyStimulus(1'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) sendByte(COM, 8);
      sendByte(COM, 7);
      checkDirected("e34_active", {7'd0, active}, 8'h00);
      sendByte(8'h01, 1);
      checkDirected("e35_active", {7'd0, active}, 8'h01);

      // The lock attempt aborts on 8'h00, then relocks on edge 56
      $display("[TB] aborted lock");
      doReset(10);
      sendByte(COM, 8);
      sendByte(COM, 8);
      sendByte(8'h00, 8);
      for (int i = 0; i < 3; i++) sendByte(COM, 8);
      sendByte(COM, 7);
      checkDirected("e55_active", {7'd0, active}, 8'h00);
      sendByte(8'h01, 1);
      checkDirected("e56_active", {7'd0, active}, 8'h01);

      // A 1-cycle reset pulse arrives mid-byte while active; relock must
      // complete within 32 edges
      $display("[TB] mid-byte reset");
      sendByte(8'h5A, 8);
      sendByte(8'h00, 4);
      applyStimulus(1'b0, 1'b1);
      checkDirected("rst_active", {7'd0, active}, 8'h00);
      checkDirected("rst_data", data_out, 8'h00);
      checkDirected("rst_valid", {7'd0, valid_out}, 8'h00);
      for (int i = 0; i < 4; i++) sendByte(COM, 8);
      checkDirected("relock_active", {7'd0, active}, 8'h01);

      // 8'h3C must not produce a false lock; lock occurs on edge 40
      $display("[TB] no false lock on 3C");
      doReset(10);
      sendByte(8'h3C, 8);
      for (int i = 0; i < 3; i++) sendByte(COM, 8);
      sendByte(COM, 7);
      checkDirected("e39_active", {7'd0, active}, 8'h00);
      sendByte(8'h01, 1);
      checkDirected("e40_active", {7'd0, active}, 8'h01);

      // Random bit soup, then COMs and random bytes, all checked by the model
      $display("[TB] random stream");
      doReset(10);
      for (int i = 0; i < 200; i++) applyStimulus(1'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) sendByte(COM, 8);
      for (int i = 0; i < 12; i++) begin
         b = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
         sendByte(b, 8);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Receive-side serial-to-parallel converter for the PHY lane. It takes the 1-bit serial stream produced by the transmit-side parallel-to-serial stage and hunts for the COM symbol (8'hBC) to find byte alignment. After a run of consecutive aligned COMs it declares the lane active. From then on it delivers each received byte with a valid flag; idle COM fill is stripped. It sits between the serial lane and the byte-unstriping stage, running entirely in the 8× byte-rate clock domain.

## Interface
- COM, 8'hBC: alignment/idle symbol.
- NUM_COM, 4: consecutive byte-aligned COMs required to go active (range 2–15).
- clk_8f  input  1  bit clock, 8× byte rate; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last received byte.
- valid_out  output  1  data_out holds a non-COM byte received while active.
- active  output  1  lane aligned and locked.

## Operation
- Every edge, including reset cycles, updates `sr <= {sr[6:0], data_in}`. Define `nxt = {sr[6:0], data_in}`.
- State `SEARCH` (reset state). Bit-by-bit hunt.
  - If `nxt == COM`: set `bit_cnt <= 0`, `com_cnt <= 1`, go to `LOCK`.
- State `LOCK`. `bit_cnt` increments every edge and wraps 7→0. A byte boundary is an edge with `bit_cnt == 7`.
  - At a boundary, if `nxt == COM`: `com_cnt++`. When `com_cnt + 1 == NUM_COM`, go to `ACTIVE` and set `active <= 1` on that edge.
  - At a boundary, if `nxt != COM`: set `com_cnt <= 0`, go to `SEARCH`. Hunting resumes on the next edge; the failed byte is not rechecked.
- State `ACTIVE`. At each boundary:
  - `data_out <= nxt`.
  - `valid_out <= (nxt != COM)`.
  - Between boundaries, `data_out` and `valid_out` hold their values.
  - COMs received while active produce `valid_out = 0`, but `data_out` still updates to 8'hBC.
- `ACTIVE` is left only by reset. There is no loss-of-sync detection in this block.
- Reset has priority over everything, including mid-byte and mid-lock.
  - Next-edge values after reset: `state = SEARCH`, `bit_cnt = 0`, `com_cnt = 0`, `data_out = 8'h00`, `valid_out = 0`, `active = 0`.
  - `sr` keeps shifting during reset, so a COM can be found on the first edge after reset deasserts.
- A COM split across a false alignment in `SEARCH` is taken as the alignment. A wrong guess fails at the next boundary and hunting restarts.

## Timing
- All outputs are registered.
- Byte latency: `data_out` and `valid_out` change on the same edge that samples the byte's LSB. The value is visible from the following cycle.
- Lock latency for a clean COM stream after reset: `active` rises on the edge that samples the LSB of the NUM_COM-th COM.
  - With NUM_COM = 4 and bits starting on edge 1 after reset, that is edge 32.
- `valid_out` can be high for at most 8 consecutive cycles per byte. Back-to-back data bytes keep it high continuously.
- `active` never falls without reset.
- `valid_out` is 0 whenever `active` is 0.

## Test plan
- Reset, then serial 8'hBC ×4 → `active` rises on edge 32. Throughout: `valid_out = 0`, `data_out = 8'h00`.
- Lock as above, then bytes 8'hFF, 8'hEE, 8'hDD, 8'hCC, then COM fill:
  - `data_out` shows FF, EE, DD, CC at edges 40, 48, 56, 64, each with `valid_out = 1`.
  - Edge 72 gives `data_out = 8'hBC`, `valid_out = 0`.
- Prefix 3 random bits, then 8'hBC ×4 → alignment found at bit offset 3; `active` rises on edge 35.
- 8'hBC ×2, then 8'h00, then 8'hBC ×4 → the lock attempt aborts at the 8'h00 boundary. `active` rises only after the fourth of the later COMs.
- Reset pulsed for 1 cycle mid-way through a data byte while active:
  - All outputs return to reset values on the next edge.
  - A following 8'hBC ×4 relocks within 32 edges.
- Stream 8'h3C, 8'hBC…: no false lock on 8'h3C. Alignment occurs only on the true COM.
